// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU operation sequencer: Y load, execute, optional mul/div settle, GPR or HI/LO write-back.
// Optional macro ALU_DIV_ZERO_TRAP_EN adds div_zero/div_trap and the DZ abort path for Divide.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// LOAD_Y | operand A from bus into Y
// EXEC   | ALU sees op_q and operand B; non-MD results captured into Z
// WAIT   | multiplier/divider settle, Z captured in the last cycle
// WB_LO  | GPR write-back (non-MD) or LO write-back (MD)
// WB_HI  | HI write-back (MD)
// ERR    | unknown opcode accepted, illegal pulse
// DZ     | divide by zero trapped (optional feature)
module alu_op_sequencer #(
  parameter int MULDIV_WAIT = 4,
  parameter int OPW         = 5
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           req_valid,
  input  logic [OPW-1:0] req_opcode,
`ifdef ALU_DIV_ZERO_TRAP_EN
  input  logic           div_zero,
  output logic           div_trap,
`endif
  output logic           req_ready,
  output logic           y_in,
  output logic           b_out,
  output logic           imm_out,
  output logic [OPW-1:0] alu_op,
  output logic           z_in,
  output logic           zlo_out,
  output logic           zhi_out,
  output logic           rz_in,
  output logic           lo_in,
  output logic           hi_in,
  output logic           done,
  output logic           illegal,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_Y, S_EXEC, S_WAIT, S_WB_LO, S_WB_HI, S_ERR, S_DZ
  } state_t;

  localparam logic [OPW-1:0] OP_DIV    = OPW'(15);
  localparam logic [OPW-1:0] OP_MUL    = OPW'(16);
  localparam logic [3:0]     WAIT_LOAD = 4'(MULDIV_WAIT - 1);

  state_t         state, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [3:0]     cnt, cnt_d;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return (op >= OPW'(3)) && (op <= OPW'(18));
  endfunction

  function automatic logic is_md(input logic [OPW-1:0] op);
    return (op == OP_DIV) || (op == OP_MUL);
  endfunction

  function automatic logic is_imm(input logic [OPW-1:0] op);
    return (op >= OPW'(12)) && (op <= OPW'(14));
  endfunction

  function automatic logic is_reg(input logic [OPW-1:0] op);
    return (op >= OPW'(3)) && (op <= OPW'(11));
  endfunction

  always_comb begin
    state_d = state;
    op_d    = op_q;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        // req_ready is itself registered high only in IDLE and out of reset
        if (req_valid && req_ready) begin
          op_d    = req_opcode;
          state_d = is_legal(req_opcode) ? S_LOAD_Y : S_ERR;
        end
      end
      S_LOAD_Y: state_d = S_EXEC;
      S_EXEC: begin
`ifdef ALU_DIV_ZERO_TRAP_EN
        if ((op_q == OP_DIV) && div_zero) begin
          state_d = S_DZ;
        end else
`endif
        if (is_md(op_q)) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = S_WB_LO;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_d = S_WB_LO;
        else             cnt_d   = cnt - 4'd1;
      end
      S_WB_LO: state_d = is_md(op_q) ? S_WB_HI : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      op_q      <= '0;
      cnt       <= '0;
      req_ready <= 1'b0;
      y_in      <= 1'b0;
      b_out     <= 1'b0;
      imm_out   <= 1'b0;
      alu_op    <= '0;
      z_in      <= 1'b0;
      zlo_out   <= 1'b0;
      zhi_out   <= 1'b0;
      rz_in     <= 1'b0;
      lo_in     <= 1'b0;
      hi_in     <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
`ifdef ALU_DIV_ZERO_TRAP_EN
      div_trap  <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      cnt       <= cnt_d;
      req_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      y_in      <= 1'b0;
      b_out     <= 1'b0;
      imm_out   <= 1'b0;
      alu_op    <= '0;
      z_in      <= 1'b0;
      zlo_out   <= 1'b0;
      zhi_out   <= 1'b0;
      rz_in     <= 1'b0;
      lo_in     <= 1'b0;
      hi_in     <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_DIV_ZERO_TRAP_EN
      div_trap  <= (state_d == S_DZ);
`endif
      case (state_d)
        S_LOAD_Y: y_in <= 1'b1;
        S_EXEC: begin
          alu_op  <= op_d;
          b_out   <= is_reg(op_d) || is_md(op_d);
          imm_out <= is_imm(op_d);
          z_in    <= !is_md(op_d);
        end
        S_WAIT: begin
          alu_op <= op_d;
          b_out  <= 1'b1;
          z_in   <= (cnt_d == 4'd0);
        end
        S_WB_LO: begin
          if (!is_md(op_d)) begin
            zlo_out <= 1'b1;
            rz_in   <= 1'b1;
            done    <= 1'b1;
          end else begin
            // Divide puts the quotient (Z high half) into LO
            zlo_out <= (op_d == OP_MUL);
            zhi_out <= (op_d == OP_DIV);
            lo_in   <= 1'b1;
          end
        end
        S_WB_HI: begin
          zhi_out <= (op_d == OP_MUL);
          zlo_out <= (op_d == OP_DIV);
          hi_in   <= 1'b1;
          done    <= 1'b1;
        end
        S_ERR:   illegal <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes the expected per-cycle strobe trace,
// a negedge monitor collects the DUT trace of each operation and compares.
module tb_alu_op_sequencer;
  localparam int W   = 4;
  localparam int OPW = 5;

  typedef logic [17:0] vec_t;
  typedef struct packed {
    logic [4:0]        op;
    logic [4:0]        len;
    logic [15:0][17:0] tr;
  } txn_t;

  localparam vec_t V_Y    = 18'h1 << 5;
  localparam vec_t V_B    = 18'h1 << 6;
  localparam vec_t V_IMM  = 18'h1 << 7;
  localparam vec_t V_Z    = 18'h1 << 8;
  localparam vec_t V_ZLO  = 18'h1 << 9;
  localparam vec_t V_ZHI  = 18'h1 << 10;
  localparam vec_t V_RZ   = 18'h1 << 11;
  localparam vec_t V_LO   = 18'h1 << 12;
  localparam vec_t V_HI   = 18'h1 << 13;
  localparam vec_t V_DONE = 18'h1 << 14;
  localparam vec_t V_ILL  = 18'h1 << 15;
  localparam vec_t V_BUSY = 18'h1 << 16;
  localparam vec_t V_RDY  = 18'h1 << 17;

  logic           clock = 1'b0;
  logic           clear = 1'b0;
  logic           req_valid = 1'b0;
  logic [OPW-1:0] req_opcode = '0;
  logic           req_ready, y_in, b_out, imm_out, z_in, zlo_out, zhi_out;
  logic           rz_in, lo_in, hi_in, done, illegal, busy;
  logic [OPW-1:0] alu_op;
`ifdef ALU_DIV_ZERO_TRAP_EN
  logic           div_zero = 1'b0;
  logic           div_trap;
`endif

  alu_op_sequencer #(.MULDIV_WAIT(W), .OPW(OPW)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_opcode(req_opcode),
`ifdef ALU_DIV_ZERO_TRAP_EN
    .div_zero(div_zero), .div_trap(div_trap),
`endif
    .req_ready(req_ready), .y_in(y_in), .b_out(b_out), .imm_out(imm_out),
    .alu_op(alu_op), .z_in(z_in), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .rz_in(rz_in), .lo_in(lo_in), .hi_in(hi_in), .done(done),
    .illegal(illegal), .busy(busy)
  );

  always #5 clock = ~clock;

  vec_t v_now;
  assign v_now = {req_ready, busy, illegal, done, hi_in, lo_in, rz_in, zhi_out,
                  zlo_out, z_in, imm_out, b_out, y_in, alu_op};

  txn_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Expected strobes for every cycle from the one after accept to the done/illegal cycle.
  function automatic txn_t model(input logic [4:0] op);
    txn_t t;
    int   n;
    t    = '0;
    t.op = op;
    n    = 0;
    if (op < 5'd3 || op > 5'd18) begin
      t.tr[0] = V_BUSY | V_ILL;
      t.len   = 5'd1;
      return t;
    end
    t.tr[n] = V_BUSY | V_Y; n++;
    if (op == 5'd15 || op == 5'd16) begin
      t.tr[n] = V_BUSY | V_B | vec_t'(op); n++;
      for (int i = 0; i < W; i++) begin
        t.tr[n] = V_BUSY | V_B | vec_t'(op) | ((i == W - 1) ? V_Z : vec_t'(0)); n++;
      end
      if (op == 5'd16) begin
        t.tr[n] = V_BUSY | V_ZLO | V_LO; n++;
        t.tr[n] = V_BUSY | V_ZHI | V_HI | V_DONE; n++;
      end else begin
        t.tr[n] = V_BUSY | V_ZHI | V_LO; n++;
        t.tr[n] = V_BUSY | V_ZLO | V_HI | V_DONE; n++;
      end
    end else begin
      t.tr[n] = V_BUSY | V_Z | vec_t'(op)
              | ((op <= 5'd11) ? V_B : vec_t'(0))
              | ((op >= 5'd12 && op <= 5'd14) ? V_IMM : vec_t'(0));
      n++;
      t.tr[n] = V_BUSY | V_ZLO | V_RZ | V_DONE; n++;
    end
    t.len = 5'(n);
    return t;
  endfunction

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // Monitor
  initial begin
    automatic bit   coll = 1'b0;
    automatic bit   after_rst = 1'b0;
    automatic bit   oh_bad = 1'b0;
    automatic int   n = 0;
    automatic txn_t got = '0;
    automatic txn_t e;
    vec_t v;
    forever begin
      @(negedge clock);
      v = v_now;
      if (!clear) begin
        tests++;
        if (v != '0) begin
          fails++;
          $display("FAIL reset_outputs got=%h exp=0", v);
        end
        coll = 1'b0;
        exp_q.delete();
        after_rst = 1'b1;
        continue;
      end
      if (after_rst) begin
        after_rst = 1'b0;
        tests++;
        if (v != '0) begin
          fails++;
          $display("FAIL reset_release_first_cycle got=%h exp=0", v);
        end
        continue;
      end
      if (!coll && v[16]) begin
        coll   = 1'b1;
        got    = '0;
        n      = 0;
        oh_bad = 1'b0;
      end
      if (coll) begin
        if (n < 16) got.tr[n] = v;
        n++;
        if ($countones({v[6], v[7], v[9], v[10]}) > 1) oh_bad = 1'b1;
        if (v[14] || v[15] || !v[16] || n >= 16) begin
          coll    = 1'b0;
          got.len = 5'(n);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_op got_len=%0d", n);
          end else begin
            e = exp_q.pop_front();
            tests++;
            if (got.len != e.len) begin
              fails++;
              $display("FAIL latency op=%0d got=%0d exp=%0d", e.op, got.len, e.len);
            end
            tests++;
            if (got.tr != e.tr) begin
              fails++;
              for (int i = 0; i < 16; i++) begin
                if (got.tr[i] != e.tr[i]) begin
                  $display("FAIL trace op=%0d cycle=%0d got=%h exp=%h", e.op, i + 1, got.tr[i], e.tr[i]);
                  break;
                end
              end
            end
            tests++;
            if (oh_bad) begin
              fails++;
              $display("FAIL bus_onehot op=%0d got=multiple exp=at_most_one", e.op);
            end
          end
        end
      end else begin
        tests++;
        if (v != V_RDY) begin
          fails++;
          $display("FAIL idle got=%h exp=%h", v, V_RDY);
        end
      end
    end
  end

  // Accepts one op; exp_gap>0 checks the number of cycles until req_ready returns for a held request.
  task automatic run_op(input logic [4:0] op, input bit hold, input int idle, input int exp_gap);
    int k;
    req_valid  = 1'b1;
    req_opcode = op;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!req_ready && k < 60);
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout op=%0d waited=%0d", op, k);
      return;
    end
    if (exp_gap > 0) begin
      tests++;
      if (k != exp_gap) begin
        fails++;
        $display("FAIL b2b_gap op=%0d got=%0d exp=%0d", op, k, exp_gap);
      end
    end
    @(posedge clock);
    exp_q.push_back(model(op));
    #1;
    req_opcode = 5'($urandom);
    if (!hold) begin
      req_valid = 1'b0;
      repeat (idle) @(posedge clock);
      #1;
    end
  endtask

  initial begin
    automatic logic [4:0] dir_ops[9] = '{5'd3, 5'd13, 5'd17, 5'd16, 5'd15, 5'd0, 5'd2, 5'd19, 5'd31};
    automatic int gap = 0;
    automatic logic [4:0] op;
    automatic bit hold;
    automatic int k;
    repeat (3) @(posedge clock);
    #1 clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Reset while a Multiply is in WAIT
    run_op(5'd16, 1'b0, 0, 0);
    repeat (4) @(posedge clock);
    #1 clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Directed ops back-to-back with the request held high
    gap = 0;
    foreach (dir_ops[i]) begin
      run_op(dir_ops[i], (i != 8), 2, gap);
      gap = (i != 8) ? int'(model(dir_ops[i]).len) + 1 : 0;
    end

    // Random ops, mostly legal, random back-to-back
    gap = 0;
    for (int i = 0; i < 80; i++) begin
      op   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 18));
      hold = ($urandom_range(0, 1) == 1) && (i != 79);
      run_op(op, hold, $urandom_range(0, 3), gap);
      gap = hold ? int'(model(op).len) + 1 : 0;
    end

    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(posedge clock);
      k++;
    end
    repeat (3) @(posedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    summary();
    $finish;
  end

  initial begin
    #300000;
    tests++; fails++;
    $display("FAIL watchdog time=%0t exp=finished", $time);
    summary();
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences one ALU operation at a time through the Y/Z-register datapath.
- Accepts an opcode via a valid/ready handshake. Strobes Y-load, B-operand drive, ALU opcode, Z capture and write-back (GPR, or HI/LO for multiply/divide).
- Adds configurable settle cycles for the combinational multiplier and divider array.
- Sits between instruction decode and the datapath bus/register enables.

Parameters:
- MULDIV_WAIT, 4, extra EXEC-hold cycles for Multiply/Divide (legal range 1..15).
- OPW, 5, opcode width; must match the ALU opcode field.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- req_valid  in  1  operation request.
- req_opcode  in  OPW  ALU opcode; same encoding as the ALU, 3..18 legal.
- req_ready  out  1  high only in IDLE; handshake completes when req_valid && req_ready.
- y_in  out  1  load bus (operand A) into Y.
- b_out  out  1  drive register operand B onto the bus (binary register ops).
- imm_out  out  1  drive the sign-extended immediate onto the bus (AddImmediate, ANDImmediate, ORImmediate).
- alu_op  out  OPW  opcode presented to the ALU.
- z_in  out  1  capture the 64-bit ALU result into Z.
- zlo_out  out  1  drive Z[31:0] onto the bus.
- zhi_out  out  1  drive Z[63:32] onto the bus.
- rz_in  out  1  write the bus into the destination GPR.
- lo_in  out  1  write the bus into LO.
- hi_in  out  1  write the bus into HI.
- done  out  1  one-cycle pulse in the final write-back cycle.
- illegal  out  1  one-cycle pulse when an unknown opcode is accepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (clear=0, async): state goes to IDLE. All strobes, done, illegal and busy are 0. alu_op = 0. req_ready = 0 while clear=0.
- Reset mid-operation aborts immediately. No further strobes are issued and no partial write-back completes.
- On accept in IDLE, the opcode is latched into op_q. req_opcode is ignored afterwards.
- Opcode classes:
  - UNARY: Negate(17), NOT(18).
  - IMM: 12, 13, 14.
  - MD: Multiply(16), Divide(15).
  - REG: 3..11.
  - Any other value is illegal.
- States: IDLE, LOAD_Y, EXEC, WAIT, WB_LO, WB_HI, ERR.
- IDLE:
  - Accept with a legal opcode goes to LOAD_Y.
  - Accept with an illegal opcode goes to ERR.
- ERR (1 cycle): illegal=1, no datapath strobes, then IDLE.
- LOAD_Y (1 cycle): y_in=1, then EXEC.
- EXEC:
  - alu_op = op_q throughout.
  - REG: b_out=1. IMM: imm_out=1. UNARY and MD-independent of class: b_out=imm_out=0 for UNARY. MD: b_out=1.
  - Non-MD: z_in=1 this cycle, then WB_LO.
  - MD: z_in=0, then WAIT.
- WAIT (MD only):
  - Counter runs MULDIV_WAIT cycles; alu_op and b_out are held.
  - z_in=1 in the last WAIT cycle, then WB_LO.
- WB_LO:
  - Non-MD: zlo_out=1, rz_in=1, done=1, then IDLE.
  - Multiply: zlo_out=1, lo_in=1, then WB_HI.
  - Divide: zhi_out=1 (quotient), lo_in=1, then WB_HI.
- WB_HI:
  - Multiply: zhi_out=1, hi_in=1.
  - Divide: zlo_out=1 (remainder), hi_in=1.
  - In both cases done=1, then IDLE.
- alu_op = 0 outside EXEC/WAIT.
- At most one bus driver (b_out, imm_out, zlo_out, zhi_out) is high per cycle.
- Latency from accept cycle to done:
  - Non-MD: 3 cycles.
  - MD: 4 + MULDIV_WAIT cycles.
- No overlap between operations. A request held high during done is accepted in the following IDLE cycle, giving 4 cycles per non-MD op back-to-back.
- All outputs are registered (Moore), decoded from state and op_q only.

Optional Feature:
- Macro: ALU_DIV_ZERO_TRAP_EN.
- When defined, adds input div_zero (1 bit, the B operand equals 0) and output div_trap (1 bit).
  - For Divide, div_zero is sampled in EXEC.
  - If div_zero=1, the FSM enters ERR-like state DZ for 1 cycle: div_trap=1, done=0, no z_in, no HI/LO writes, then IDLE.
  - For other opcodes, div_zero is ignored.
- When not defined: the port is absent, and Divide by zero completes normally with whatever the divider outputs.

Test Plan:
- Reset: clear=0 during WAIT of a Multiply -> all outputs 0 on the same cycle; clear released -> req_ready=1 next cycle, no hi_in/lo_in ever seen for the aborted op.
- Add (opcode 3) accepted at cycle 0 -> y_in at cycle 1; b_out+z_in with alu_op=3 at cycle 2; zlo_out+rz_in+done at cycle 3; req_ready=1 at cycle 4.
- ANDImmediate (13) and Negate (17) -> imm_out=1 (b_out=0) and b_out=imm_out=0 respectively in EXEC; rz_in write-back; 3-cycle latency.
- Multiply (16), MULDIV_WAIT=4 -> alu_op=16 held for cycles 2..6, z_in at cycle 6; cycle 7 zlo_out+lo_in; cycle 8 zhi_out+hi_in+done.
- Divide (15) -> cycle 7 zhi_out+lo_in (quotient to LO); cycle 8 zlo_out+hi_in+done; with ALU_DIV_ZERO_TRAP_EN and div_zero=1 -> div_trap pulse at cycle 3, no z_in/lo_in/hi_in.
- Illegal opcodes 0, 2, 19 and 31 -> illegal pulse one cycle after accept, no strobes; back-to-back request held high -> next accept occurs in the immediately following IDLE cycle.
